// File: rtl/alu_issue_pkg.sv
// Shared constants for the ALU issue slice: op codes and register-address width.
// Both the issue block and the external ALU decode op codes from here.
package alu_issue_pkg;
   localparam int REG_AW = 3;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SHL = 3'b101;
   localparam logic [2:0] ALU_SHR = 3'b110;
   localparam logic [2:0] ALU_SRA = 3'b111;

   typedef logic [REG_AW-1:0] reg_addr_t;
endpackage

// File: rtl/alu_issue_if.sv
// Bundles the instruction, ALU and result handshakes of alu_issue.
// The slave modport is the issue block's view; master is the surrounding system.
interface alu_issue_if
   import alu_issue_pkg::*;
   #(parameter int data_width = 32) ();

   logic                  in_valid;
   logic                  in_ready;
   logic [2:0]            in_ctrl;
   reg_addr_t             in_rd;
   reg_addr_t             in_rs1;
   reg_addr_t             in_rs2;
   logic                  in_imm_en;
   logic [data_width-1:0] in_imm;

   logic [data_width-1:0] alu_a;
   logic [data_width-1:0] alu_b;
   logic [2:0]            alu_ctrl;
   logic [data_width-1:0] alu_out;

   logic                  res_valid;
   logic                  res_ready;
   reg_addr_t             res_rd;
   logic [data_width-1:0] res_data;

   modport slave (
      input  in_valid, in_ctrl, in_rd, in_rs1, in_rs2, in_imm_en, in_imm,
      input  alu_out, res_ready,
      output in_ready, alu_a, alu_b, alu_ctrl, res_valid, res_rd, res_data
   );

   modport master (
      output in_valid, in_ctrl, in_rd, in_rs1, in_rs2, in_imm_en, in_imm,
      output alu_out, res_ready,
      input  in_ready, alu_a, alu_b, alu_ctrl, res_valid, res_rd, res_data
   );
endinterface

// File: rtl/alu_regfile.sv
// Register file with two combinational read ports and one synchronous write port.
// Register 0 reads as zero and ignores writes.
module alu_regfile
   import alu_issue_pkg::*;
   #(parameter int data_width = 32,
     parameter int reg_count  = 8)
   (input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  reg_addr_t             wa,
    input  logic [data_width-1:0] wd,
    input  reg_addr_t             ra1,
    input  reg_addr_t             ra2,
    output logic [data_width-1:0] rd1,
    output logic [data_width-1:0] rd2);

   logic [data_width-1:0] regs [reg_count];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < reg_count; i++) regs[i] <= '0;
      end else if (we && wa != '0) begin
         regs[wa] <= wd;
      end
   end

   assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
   assign rd2 = (ra2 == '0) ? '0 : regs[ra2];
endmodule

// File: rtl/alu_issue.sv
// Two-stage issue pipeline (EX, WB) around an external combinational ALU,
// with operand forwarding from EX and WB and a skid-free valid/ready flow.
module alu_issue
   import alu_issue_pkg::*;
   #(parameter int data_width = 32,
     parameter int reg_count  = 8)
   (input logic        clk,
    input logic        rst,
    alu_issue_if.slave bus);

   logic                  ex_valid;
   reg_addr_t             ex_rd;
   logic                  wb_adv;
   logic                  ex_adv;
   logic                  accept;
   logic                  rf_we;
   logic [data_width-1:0] rf_a;
   logic [data_width-1:0] rf_b;
   logic [data_width-1:0] op_a;
   logic [data_width-1:0] op_b;

   assign wb_adv      = !bus.res_valid || bus.res_ready;
   assign ex_adv      = !ex_valid || wb_adv;
   assign bus.in_ready = ex_adv && !rst;
   assign accept      = bus.in_valid && bus.in_ready;
   assign rf_we       = bus.res_valid && bus.res_ready;

   alu_regfile #(.data_width(data_width), .reg_count(reg_count)) u_regfile (
      .clk (clk),
      .rst (rst),
      .we  (rf_we),
      .wa  (bus.res_rd),
      .wd  (bus.res_data),
      .ra1 (bus.in_rs1),
      .ra2 (bus.in_rs2),
      .rd1 (rf_a),
      .rd2 (rf_b)
   );

   // Youngest producer wins: the EX result is newer than the WB result,
   // which in turn is newer than (or being written to) the register file.
   always_comb begin
      op_a = rf_a;
      if (bus.in_rs1 == '0)
         op_a = '0;
      else if (ex_valid && ex_rd == bus.in_rs1)
         op_a = bus.alu_out;
      else if (bus.res_valid && bus.res_rd == bus.in_rs1)
         op_a = bus.res_data;

      op_b = rf_b;
      if (bus.in_rs2 == '0)
         op_b = '0;
      else if (ex_valid && ex_rd == bus.in_rs2)
         op_b = bus.alu_out;
      else if (bus.res_valid && bus.res_rd == bus.in_rs2)
         op_b = bus.res_data;
      if (bus.in_imm_en)
         op_b = bus.in_imm;
   end

   // EX stage: operands and op code presented to the ALU
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid     <= 1'b0;
         ex_rd        <= '0;
         bus.alu_a    <= '0;
         bus.alu_b    <= '0;
         bus.alu_ctrl <= ALU_ADD;
      end else if (ex_adv) begin
         ex_valid <= accept;
         if (accept) begin
            ex_rd        <= bus.in_rd;
            bus.alu_a    <= op_a;
            bus.alu_b    <= op_b;
            bus.alu_ctrl <= bus.in_ctrl;
         end
      end
   end

   // WB stage: result held until downstream accepts it
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.res_valid <= 1'b0;
         bus.res_rd    <= '0;
         bus.res_data  <= '0;
      end else if (wb_adv) begin
         bus.res_valid <= ex_valid;
         if (ex_valid) begin
            bus.res_rd   <= ex_rd;
            bus.res_data <= bus.alu_out;
         end
      end
   end
endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue at 16-bit width: directed scenarios plus random traffic
// checked against an in-order architectural register model.
module tb_alu_issue;
   import alu_issue_pkg::*;

   localparam int DW = 16;

   typedef struct packed {
      logic [2:0]    rd;
      logic [DW-1:0] data;
   } res_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_issue_if #(.data_width(DW)) bif ();

   alu_issue #(.data_width(DW), .reg_count(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif.slave)
   );

   // External combinational ALU
   always_comb begin
      case (bif.alu_ctrl)
         ALU_ADD: bif.alu_out = bif.alu_a + bif.alu_b;
         ALU_SUB: bif.alu_out = bif.alu_a - bif.alu_b;
         ALU_AND: bif.alu_out = bif.alu_a & bif.alu_b;
         ALU_OR:  bif.alu_out = bif.alu_a | bif.alu_b;
         ALU_XOR: bif.alu_out = bif.alu_a ^ bif.alu_b;
         ALU_SHL: bif.alu_out = bif.alu_a << bif.alu_b;
         ALU_SHR: bif.alu_out = bif.alu_a >> bif.alu_b;
         default: bif.alu_out = $signed(bif.alu_a) >>> bif.alu_b;
      endcase
   end

   int            errors = 0;
   int            checks = 0;
   bit            rand_rdy = 1'b0;
   logic [DW-1:0] mrf [8];
   res_t          exp_q [$];
   res_t          got_q [$];
   int            last_wait;

   function automatic logic [DW-1:0] ref_op(input logic [2:0] op,
                                            input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return a << b;
         3'd6:    return a >> b;
         default: return $signed(a) >>> b;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_rdy) bif.res_ready = ($urandom_range(0, 3) != 0);
      #1;
   endtask

   task automatic drive(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic ie, input logic [DW-1:0] imm);
      bif.in_ctrl   = op;
      bif.in_rd     = rd;
      bif.in_rs1    = rs1;
      bif.in_rs2    = rs2;
      bif.in_imm_en = ie;
      bif.in_imm    = imm;
      bif.in_valid  = 1'b1;
   endtask

   // Architectural effect of the instruction currently on the input bus
   task automatic model_accept();
      logic [DW-1:0] a, b, r;
      a = (bif.in_rs1 == 3'd0) ? '0 : mrf[bif.in_rs1];
      b = bif.in_imm_en ? bif.in_imm : ((bif.in_rs2 == 3'd0) ? '0 : mrf[bif.in_rs2]);
      r = ref_op(bif.in_ctrl, a, b);
      if (bif.in_rd != 3'd0) mrf[bif.in_rd] = r;
      exp_q.push_back({bif.in_rd, r});
   endtask

   task automatic wait_accept(output int waited);
      waited = 0;
      #1;
      while (!bif.in_ready && waited < 100) begin
         tick();
         waited++;
      end
      if (!bif.in_ready) begin
         chk("accept_timeout", 32'(bif.in_ready), 32'd1);
      end else begin
         model_accept();
         tick();
      end
      bif.in_valid = 1'b0;
   endtask

   task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic ie, input logic [DW-1:0] imm);
      drive(op, rd, rs1, rs2, ie, imm);
      wait_accept(last_wait);
   endtask

   task automatic drain();
      int n = 0;
      bif.in_valid  = 1'b0;
      rand_rdy      = 1'b0;
      bif.res_ready = 1'b1;
      while (exp_q.size() != 0 && n < 200) begin
         tick();
         n++;
      end
      chk("drain_pending", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic expect_got(input string tag, input logic [2:0] rd, input logic [DW-1:0] data);
      res_t g;
      if (got_q.size() == 0) begin
         chk({tag, "_missing"}, 32'(got_q.size()), 32'd1);
      end else begin
         g = got_q.pop_front();
         chk({tag, "_rd"}, 32'(g.rd), 32'(rd));
         chk({tag, "_data"}, 32'(g.data), 32'(data));
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      for (int i = 0; i < 8; i++) mrf[i] = '0;
   endtask

   // Result monitor: in-order scoreboard plus stability while stalled
   bit   prev_stall = 1'b0;
   res_t prev_res;
   always @(negedge clk) begin
      res_t e;
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", 32'(bif.res_valid), 32'd1);
            chk("stall_rd", 32'(bif.res_rd), 32'(prev_res.rd));
            chk("stall_data", 32'(bif.res_data), 32'(prev_res.data));
         end
         if (bif.res_valid && bif.res_ready) begin
            got_q.push_back({bif.res_rd, bif.res_data});
            if (exp_q.size() == 0) begin
               chk("spurious_result", 32'(bif.res_valid), 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("res_rd", 32'(bif.res_rd), 32'(e.rd));
               chk("res_data", 32'(bif.res_data), 32'(e.data));
            end
         end
         prev_stall = bif.res_valid && !bif.res_ready;
         prev_res   = {bif.res_rd, bif.res_data};
      end
   end

   initial begin
      int w_sum;
      rst           = 1'b1;
      bif.in_valid  = 1'b0;
      bif.in_ctrl   = 3'd0;
      bif.in_rd     = 3'd0;
      bif.in_rs1    = 3'd0;
      bif.in_rs2    = 3'd0;
      bif.in_imm_en = 1'b0;
      bif.in_imm    = '0;
      bif.res_ready = 1'b1;
      model_reset();
      tick();
      tick();

      chk("rst_res_valid", 32'(bif.res_valid), 32'd0);
      chk("rst_in_ready", 32'(bif.in_ready), 32'd0);
      chk("rst_alu_a", 32'(bif.alu_a), 32'd0);
      chk("rst_alu_b", 32'(bif.alu_b), 32'd0);
      chk("rst_alu_ctrl", 32'(bif.alu_ctrl), 32'd0);
      chk("rst_res_rd", 32'(bif.res_rd), 32'd0);
      chk("rst_res_data", 32'(bif.res_data), 32'd0);
      rst = 1'b0;
      tick();
      chk("idle_in_ready", 32'(bif.in_ready), 32'd1);

      // Single add and its two-cycle latency
      got_q.delete();
      issue(3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'd5);
      chk("lat_ex_only", 32'(bif.res_valid), 32'd0);
      tick();
      chk("lat_res_valid", 32'(bif.res_valid), 32'd1);
      chk("lat_res_rd", 32'(bif.res_rd), 32'd1);
      chk("lat_res_data", 32'(bif.res_data), 32'd5);
      issue(3'd0, 3'd0, 3'd1, 3'd0, 1'b1, 16'd0);
      drain();
      expect_got("add5", 3'd1, 16'd5);
      expect_got("read_r1", 3'd0, 16'd5);

      // Back-to-back dependent chain through EX and WB forwarding
      got_q.delete();
      w_sum = 0;
      issue(3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'd7);
      w_sum += last_wait;
      issue(3'd0, 3'd2, 3'd1, 3'd1, 1'b0, 16'd0);
      w_sum += last_wait;
      issue(3'd1, 3'd3, 3'd2, 3'd1, 1'b0, 16'd0);
      w_sum += last_wait;
      chk("b2b_stall_cycles", 32'(w_sum), 32'd0);
      drain();
      expect_got("chain_r1", 3'd1, 16'd7);
      expect_got("chain_r2", 3'd2, 16'd14);
      expect_got("chain_r3", 3'd3, 16'd7);

      // Downstream backpressure with three instructions queued
      got_q.delete();
      bif.res_ready = 1'b0;
      issue(3'd0, 3'd4, 3'd0, 3'd0, 1'b1, 16'h0011);
      issue(3'd0, 3'd5, 3'd4, 3'd0, 1'b1, 16'h0022);
      drive(3'd4, 3'd6, 3'd5, 3'd4, 1'b0, 16'h0000);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("bp_in_ready", 32'(bif.in_ready), 32'd0);
         chk("bp_res_data", 32'(bif.res_data), 32'h0011);
         tick();
      end
      bif.res_ready = 1'b1;
      wait_accept(last_wait);
      drain();
      expect_got("bp_r4", 3'd4, 16'h0011);
      expect_got("bp_r5", 3'd5, 16'h0033);
      expect_got("bp_r6", 3'd6, 16'h0022);

      // Writes to r0 are emitted but never become visible
      got_q.delete();
      issue(3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 16'd9);
      issue(3'd0, 3'd7, 3'd0, 3'd0, 1'b0, 16'd0);
      drain();
      issue(3'd0, 3'd7, 3'd0, 3'd0, 1'b0, 16'd0);
      drain();
      expect_got("r0_write", 3'd0, 16'd9);
      expect_got("r0_fwd_read", 3'd7, 16'd0);
      expect_got("r0_rf_read", 3'd7, 16'd0);

      // 16-bit wrap and arithmetic shift of a negative value
      got_q.delete();
      issue(3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'hFFFF);
      issue(3'd0, 3'd2, 3'd1, 3'd0, 1'b1, 16'h0001);
      issue(3'd7, 3'd3, 3'd1, 3'd0, 1'b1, 16'h0003);
      drain();
      expect_got("wrap_r1", 3'd1, 16'hFFFF);
      expect_got("wrap_r2", 3'd2, 16'h0000);
      expect_got("sra_r3", 3'd3, 16'hFFFF);

      // Random traffic with random downstream stalls
      rand_rdy = 1'b1;
      for (int i = 0; i < 300; i++) begin
         logic [DW-1:0] imm;
         imm = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 17)) : DW'($urandom);
         issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), imm);
         for (int g = $urandom_range(0, 3); g > 2; g--) tick();
      end
      drain();

      // Reset with two instructions in flight, write port enabled
      bif.res_ready = 1'b0;
      issue(3'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0055);
      issue(3'd0, 3'd2, 3'd0, 3'd0, 1'b1, 16'h0066);
      rst = 1'b1;
      bif.res_ready = 1'b1;
      model_reset();
      tick();
      chk("mid_rst_res_valid", 32'(bif.res_valid), 32'd0);
      chk("mid_rst_in_ready", 32'(bif.in_ready), 32'd0);
      rst = 1'b0;
      tick();
      got_q.delete();
      for (int r = 1; r < 8; r++) issue(3'd0, 3'd0, 3'(r), 3'd0, 1'b1, 16'd0);
      drain();
      for (int r = 1; r < 8; r++) expect_got($sformatf("post_rst_r%0d", r), 3'd0, 16'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
